kc_ls1u_intc: RTL and testbench
===============================

Name: kc_ls1u_intc

Overview:
Interrupt controller on the receiving end of the LS1u+ core's INT/IVEC_addr/IN_ISP interface. It collects up to 8 external interrupt sources and prioritises them (lowest index wins). It drives a single-cycle-accepted INT request plus a per-source vector address to the core, and tracks the in-service state through IN_ISP. Software configures it through memory-mapped 8-bit registers on the core's data bus (daddr/dread/dwrite).

Parameters:
NSRC, 8, number of interrupt sources (1..8); unused register bits read 0, writes ignored
BASE_ADDR, 24'hFFFF00, register block base; decode on daddr[23:3]==BASE_ADDR[23:3]
VEC_BASE, 24'h000100, vector for source 0
VEC_STRIDE_LOG2, 4, vector spacing = 2**VEC_STRIDE_LOG2 words

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  reset, synchronous, active-high
irq_src  in  NSRC  asynchronous interrupt inputs
daddr  in  24  core data address {A2,A1,A0}
dread  in  1  core load strobe (combinational, same cycle as data sample)
dwrite  in  1  core store strobe (one-cycle pulse, data valid same cycle)
ddata_i  in  8  store data (core MDR)
ddata_o  out  8  load data; 0 when not selected
dsel  out  1  dread & address hit (for bus read mux)
INT  out  1  interrupt request to core (registered)
IVEC_addr  out  24  vector of requested/active source (registered)
IN_ISP  in  1  core in-service flag

Behaviour:
- Register map (daddr[2:0]): 0 PEND (R; W1C). 1 MASK (R/W; 1=enabled). 2 EDGE (R/W; 1=rising-edge, 0=level). 3 ACTIVE (R: {IN_ISP, 4'b0, act_id[2:0]}). 4 SWI (W: 1 sets PEND bit; reads 0). 5-7: read 0, write ignored.
- Reads: combinational and side-effect free. ddata_o valid in the same cycle as dread. dsel/ddata_o are 0 when dread=0 or the address misses.
- Writes: take effect at the clk edge where dwrite=1 and the address hits.
- Input path: 2-flop synchroniser (s1,s2), plus s3 = previous s2 for edge detection.
- PEND[i] set: EDGE[i]=1 and s2&~s3; or EDGE[i]=0 and s2=1; or SWI write bit i=1.
- PEND[i] clear: PEND W1C bit i=1, or acceptance of source i.
- Set beats clear in the same cycle. A level source still high re-pends on the next cycle after clear.
- req_vec = PEND & MASK. sel_id = lowest set index of req_vec.
- FSM IDLE:
  - If req_vec!=0 and IN_ISP=0: go to REQ, latch act_id<=sel_id, IVEC_addr<=VEC_BASE+(sel_id<<VEC_STRIDE_LOG2), INT<=1.
- FSM REQ:
  - INT held high; act_id and IVEC_addr frozen.
  - On IN_ISP=1: go to SERVICE, INT<=0, clear PEND[act_id] (unless set again in that cycle).
  - No withdrawal: masking or W1C of the requested source while in REQ does not drop INT.
- FSM SERVICE:
  - INT=0; IVEC_addr and act_id held.
  - On IN_ISP=0 (core RET): go to IDLE. A new request can assert INT on the following edge at the earliest.
- Latency: irq_src sampled high at edge k gives s1@k, s2@k+1, PEND@k+2, INT=1 after edge k+3.
- The core normally accepts in the first INT cycle, so REQ lasts 1 cycle unless the core is stalled.
- Nesting: none. No IDLE->REQ while IN_ISP=1, even if IDLE was entered with IN_ISP already high.
- Reset values: state=IDLE, INT=0, IVEC_addr=VEC_BASE, act_id=0, PEND=0, MASK=0, EDGE=0, s1/s2/s3=0. ddata_o/dsel follow the combinational rule (0 with dread=0).
- Reset mid-REQ/SERVICE: everything returns to reset values next edge; the core's own reset handles its ISR state.

Test Plan:
- Reset, MASK=0x04, EDGE=0x04, pulse irq_src[2] for 1 cycle -> PEND=0x04 at k+2, INT=1 after k+3, IVEC_addr=0x000120. IN_ISP=1 next cycle -> INT=0, PEND=0x00, ACTIVE=0x82.
- MASK=0xFF, level sources 1 and 5 held high together -> IVEC_addr=0x000110 (id 1). After IN_ISP 1->0 with src1 still high -> id 1 again. Drop src1, W1C 0x02 -> next request id 5, vector 0x000150.
- PEND W1C of bit 3 in the same cycle as a rising edge on src3 (edge mode) -> PEND[3] stays 1.
- SWI write 0x80 with MASK=0x80 -> INT asserted 1 cycle after write edge, vector VEC_BASE+0x70. MASK=0x00 case -> PEND=0x80, INT stays 0.
- Hold IN_ISP=1 while src0 pends -> INT stays 0. IN_ISP falls -> INT=1 one edge later.
- Assert rst during REQ -> INT=0, PEND=MASK=EDGE=0, IVEC_addr=0x000100. Reads at BASE+0..7 return 0; dread to a non-matching address -> dsel=0, ddata_o=0.

Source files
------------

// File: rtl/kc_ls1u_intc.sv
// kc_ls1u_intc: 8-source priority interrupt controller for the LS1u+ core.
// Ports: clk/rst (sync, active-high); irq_src async inputs; daddr/dread/
//   dwrite/ddata_i/ddata_o/dsel memory-mapped register bus; INT/IVEC_addr
//   request + vector to the core; IN_ISP core in-service flag.
// Registers (daddr[2:0]): 0 PEND (R/W1C), 1 MASK, 2 EDGE, 3 ACTIVE (R),
//   4 SWI (W1 sets PEND), 5-7 reserved (read 0).
module kc_ls1u_intc #(
    parameter int          NSRC            = 8,
    parameter logic [23:0] BASE_ADDR       = 24'hFFFF00,
    parameter logic [23:0] VEC_BASE        = 24'h000100,
    parameter int          VEC_STRIDE_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic [23:0]     daddr,
    input  logic            dread,
    input  logic            dwrite,
    input  logic [7:0]      ddata_i,
    output logic [7:0]      ddata_o,
    output logic            dsel,
    output logic            INT,
    output logic [23:0]     IVEC_addr,
    input  logic            IN_ISP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [NSRC-1:0] s1_q, s1_d;
    logic [NSRC-1:0] s2_q, s2_d;
    logic [NSRC-1:0] s3_q, s3_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_q, edge_d;
    logic [2:0]      act_id_q, act_id_d;
    logic [23:0]     ivec_q, ivec_d;
    logic            int_q, int_d;

    logic            hit;
    logic            wr_hit;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] swi;
    logic [NSRC-1:0] set_v;
    logic [NSRC-1:0] acc_clr;
    logic [NSRC-1:0] req_vec;
    logic [2:0]      sel_id;
    logic [23:0]     sel_vec;
    logic [7:0]      pend8;
    logic [7:0]      mask8;
    logic [7:0]      edge8;

    assign hit     = (daddr[23:3] == BASE_ADDR[23:3]);
    assign wr_hit  = dwrite & hit;
    assign dsel    = dread & hit;
    assign req_vec = pend_q & mask_q;

    assign INT       = int_q;
    assign IVEC_addr = ivec_q;

    // Zero-extend the NSRC-wide registers for the 8-bit bus.
    always_comb begin
        pend8 = '0;
        mask8 = '0;
        edge8 = '0;
        pend8[NSRC-1:0] = pend_q;
        mask8[NSRC-1:0] = mask_q;
        edge8[NSRC-1:0] = edge_q;
    end

    // Side-effect-free combinational read port.
    always_comb begin
        ddata_o = '0;
        if (dsel) begin
            unique case (daddr[2:0])
                3'd0:    ddata_o = pend8;
                3'd1:    ddata_o = mask8;
                3'd2:    ddata_o = edge8;
                3'd3:    ddata_o = {IN_ISP, 4'b0000, act_id_q};
                default: ddata_o = '0;
            endcase
        end
    end

    // Register writes.
    always_comb begin
        w1c    = '0;
        swi    = '0;
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_hit) begin
            unique case (daddr[2:0])
                3'd0:    w1c    = ddata_i[NSRC-1:0];
                3'd1:    mask_d = ddata_i[NSRC-1:0];
                3'd2:    edge_d = ddata_i[NSRC-1:0];
                3'd4:    swi    = ddata_i[NSRC-1:0];
                default: ;
            endcase
        end
    end

    // Synchroniser; s3 is the previous s2 for rising-edge detection.
    always_comb begin
        s1_d = irq_src;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Lowest index wins.
    always_comb begin
        sel_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_vec[i]) sel_id = 3'(i);
        end
    end

    assign sel_vec = VEC_BASE + ({21'd0, sel_id} << VEC_STRIDE_LOG2);

    // Request / service FSM.
    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        act_id_d = act_id_q;
        ivec_d   = ivec_q;
        acc_clr  = '0;
        unique case (state_q)
            ST_IDLE: begin
                int_d = 1'b0;
                if ((|req_vec) && !IN_ISP) begin
                    state_d  = ST_REQ;
                    act_id_d = sel_id;
                    ivec_d   = sel_vec;
                    int_d    = 1'b1;
                end
            end
            ST_REQ: begin
                // No withdrawal: the request stands until the core accepts.
                int_d = 1'b1;
                if (IN_ISP) begin
                    state_d           = ST_SVC;
                    int_d             = 1'b0;
                    acc_clr[act_id_q] = 1'b1;
                end
            end
            ST_SVC: begin
                int_d = 1'b0;
                if (!IN_ISP) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    // Pending bits: a set in the same cycle beats any clear.
    always_comb begin
        set_v  = (edge_q & s2_q & ~s3_q) | (~edge_q & s2_q) | swi;
        pend_d = (pend_q & ~(w1c | acc_clr)) | set_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            act_id_q <= '0;
            ivec_q   <= VEC_BASE;
            int_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            act_id_q <= act_id_d;
            ivec_q   <= ivec_d;
            int_q    <= int_d;
        end
    end

endmodule

// File: tb/tb_kc_ls1u_intc.sv
// tb_kc_ls1u_intc: directed self-checking bench for kc_ls1u_intc.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_kc_ls1u_intc;

    localparam logic [23:0] BASE = 24'hFFFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic [23:0] daddr = '0;
    logic        dread = 1'b0;
    logic        dwrite = 1'b0;
    logic [7:0]  ddata_i = '0;
    logic [7:0]  ddata_o;
    logic        dsel;
    logic        INT;
    logic [23:0] IVEC_addr;
    logic        IN_ISP = 1'b0;

    int checks = 0;
    int failures = 0;

    kc_ls1u_intc dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .daddr     (daddr),
        .dread     (dread),
        .dwrite    (dwrite),
        .ddata_i   (ddata_i),
        .ddata_o   (ddata_o),
        .dsel      (dsel),
        .INT       (INT),
        .IVEC_addr (IVEC_addr),
        .IN_ISP    (IN_ISP)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        daddr   = BASE | {21'd0, a};
        ddata_i = d;
        dwrite  = 1'b1;
        tick();
        dwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [7:0] exp);
        daddr = BASE | {21'd0, a};
        dread = 1'b1;
        #1;
        chk({tag, "_dsel"}, {31'd0, dsel}, 32'd1);
        chk(tag, {24'd0, ddata_o}, {24'd0, exp});
        dread = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_int", {31'd0, INT}, 32'd0);
        chk("rst_ivec", {8'd0, IVEC_addr}, 32'h000100);
        rd("rst_pend", 3'd0, 8'h00);
        rd("rst_mask", 3'd1, 8'h00);

        // Edge source 2, single-cycle pulse
        wr(3'd1, 8'h04);
        wr(3'd2, 8'h04);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        tick();
        rd("t1_pend_k1", 3'd0, 8'h00);
        tick();
        rd("t1_pend_k2", 3'd0, 8'h04);
        chk("t1_int_k2", {31'd0, INT}, 32'd0);
        tick();
        chk("t1_int_k3", {31'd0, INT}, 32'd1);
        chk("t1_ivec", {8'd0, IVEC_addr}, 32'h000120);
        IN_ISP = 1'b1;
        tick();
        chk("t1_int_acc", {31'd0, INT}, 32'd0);
        rd("t1_pend_acc", 3'd0, 8'h00);
        rd("t1_active", 3'd3, 8'h82);
        IN_ISP = 1'b0;
        tick();

        // Level sources 1 and 5
        wr(3'd1, 8'hFF);
        irq_src = 8'h22;
        tick();
        tick();
        tick();
        chk("t2_int_early", {31'd0, INT}, 32'd0);
        tick();
        chk("t2_int", {31'd0, INT}, 32'd1);
        chk("t2_ivec1", {8'd0, IVEC_addr}, 32'h000110);
        IN_ISP = 1'b1;
        tick();
        chk("t2_int_acc", {31'd0, INT}, 32'd0);
        rd("t2_pend_repend", 3'd0, 8'h22);
        rd("t2_active", 3'd3, 8'h81);
        IN_ISP = 1'b0;
        tick();
        tick();
        chk("t2_int_again", {31'd0, INT}, 32'd1);
        chk("t2_ivec1_again", {8'd0, IVEC_addr}, 32'h000110);
        IN_ISP = 1'b1;
        irq_src = 8'h20;
        tick();
        tick();
        tick();
        wr(3'd0, 8'h02);
        rd("t2_pend_w1c", 3'd0, 8'h20);
        IN_ISP = 1'b0;
        tick();
        tick();
        chk("t2_int5", {31'd0, INT}, 32'd1);
        chk("t2_ivec5", {8'd0, IVEC_addr}, 32'h000150);
        IN_ISP = 1'b1;
        irq_src = 8'h00;
        tick();
        tick();
        tick();
        wr(3'd0, 8'h20);
        IN_ISP = 1'b0;
        tick();
        tick();
        chk("t2_idle_int", {31'd0, INT}, 32'd0);
        rd("t2_pend_empty", 3'd0, 8'h00);

        // W1C racing a rising edge on source 3
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h0C);
        irq_src = 8'h08;
        tick();
        tick();
        wr(3'd0, 8'h08);
        rd("t3_set_beats_clr", 3'd0, 8'h08);
        wr(3'd0, 8'h08);
        rd("t3_cleared", 3'd0, 8'h00);
        irq_src = 8'h00;

        // Software interrupt on source 7
        wr(3'd1, 8'h80);
        wr(3'd4, 8'h80);
        rd("t4_pend", 3'd0, 8'h80);
        rd("t4_swi_read", 3'd4, 8'h00);
        chk("t4_int_w", {31'd0, INT}, 32'd0);
        tick();
        chk("t4_int_w1", {31'd0, INT}, 32'd1);
        chk("t4_ivec", {8'd0, IVEC_addr}, 32'h000170);
        IN_ISP = 1'b1;
        tick();
        IN_ISP = 1'b0;
        tick();
        wr(3'd1, 8'h00);
        wr(3'd4, 8'h80);
        rd("t4_pend_masked", 3'd0, 8'h80);
        tick();
        tick();
        chk("t4_int_masked", {31'd0, INT}, 32'd0);
        wr(3'd0, 8'h80);

        // IN_ISP held high blocks a new request
        wr(3'd1, 8'h01);
        IN_ISP = 1'b1;
        irq_src = 8'h01;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("t5_blocked", {31'd0, INT}, 32'd0);
        rd("t5_pend", 3'd0, 8'h01);
        IN_ISP = 1'b0;
        tick();
        chk("t5_int", {31'd0, INT}, 32'd1);
        chk("t5_ivec", {8'd0, IVEC_addr}, 32'h000100);

        // Reset while in REQ
        rst = 1'b1;
        irq_src = 8'h00;
        tick();
        rst = 1'b0;
        chk("t6_int", {31'd0, INT}, 32'd0);
        chk("t6_ivec", {8'd0, IVEC_addr}, 32'h000100);
        for (int a = 0; a < 8; a++) begin
            rd($sformatf("t6_rd%0d", a), 3'(a), 8'h00);
        end
        daddr = BASE;
        dread = 1'b0;
        #1;
        chk("t6_noread_dsel", {31'd0, dsel}, 32'd0);
        chk("t6_noread_data", {24'd0, ddata_o}, 32'd0);
        daddr = 24'hFFFE01;
        dread = 1'b1;
        #1;
        chk("t6_miss_dsel", {31'd0, dsel}, 32'd0);
        chk("t6_miss_data", {24'd0, ddata_o}, 32'd0);
        dread = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
